// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared FSM state encoding and constants for the clock frequency meter
package clk_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;
  localparam int unsigned ARM_CYCLES = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus rising-edge detector for an asynchronous input
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);
  logic [2:0] sr_q;
  always_ff @(posedge clk) sr_q <= rst ? 3'b000 : {sr_q[1:0], async_i};
  assign rise_o = sr_q[1] & ~sr_q[2];
endmodule

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts meas_clk rising edges over a fixed clk window and range-checks the result
module clk_freq_meter
  import clk_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 48000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             start,
  input  logic [CNT_W-1:0] expected,
  input  logic [CNT_W-1:0] tol,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             in_range
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] exp_q, tol_q, edges_q, edges_d, count_q;
  logic [GW-1:0] gate_q, gate_d;
  logic [AW-1:0] arm_q, arm_d;
  logic sat_q, sat_d, ovf_q, inr_q, rise, gate_end, take;
  logic [CNT_W:0] diff;
  sync_edge_det u_sync (.clk(clk), .rst(rst), .async_i(meas_clk), .rise_o(rise));
  always_comb begin
    state_d  = state_q;
    arm_d    = arm_q;
    gate_d   = gate_q;
    edges_d  = edges_q;
    sat_d    = sat_q;
    take     = state_q == IDLE && start;
    gate_end = state_q == MEASURE && gate_q == GATE_LAST;
    case (state_q)
      IDLE: begin
        arm_d   = '0;
        state_d = start ? ARM : IDLE;
      end
      ARM: begin
        arm_d   = arm_q + 1'b1;
        gate_d  = '0;
        edges_d = '0;
        sat_d   = 1'b0;
        state_d = arm_q == ARM_LAST ? MEASURE : ARM;
      end
      MEASURE: begin
        gate_d  = gate_q + 1'b1;
        // saturate instead of wrapping; an edge arriving at full scale marks overflow
        edges_d = rise && !(&edges_q) ? edges_q + 1'b1 : edges_q;
        sat_d   = sat_q | (rise & (&edges_q));
        state_d = gate_end ? DONE : MEASURE;
      end
      DONE: state_d = IDLE;
    endcase
    diff = edges_d >= exp_q ? {1'b0, edges_d} - {1'b0, exp_q} : {1'b0, exp_q} - {1'b0, edges_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      arm_q   <= '0;
      gate_q  <= '0;
      edges_q <= '0;
      sat_q   <= 1'b0;
      exp_q   <= '0;
      tol_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      inr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      gate_q  <= gate_d;
      edges_q <= edges_d;
      sat_q   <= sat_d;
      if (take) begin
        exp_q <= expected;
        tol_q <= tol;
      end
      if (gate_end) begin
        count_q <= edges_d;
        ovf_q   <= sat_d;
        inr_q   <= !sat_d && diff <= {1'b0, tol_q};
      end
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign in_range = inr_q;
endmodule
